// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline stall/flush sequencer with mult/div busy tracking
// Optional stall counter output is built when STALL_CNT_EN is defined.
module hazard_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_is_div,
    output logic        pc_we,
    output logic        d_we,
    output logic        e_flush,
    output logic        md_busy
`ifdef STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    if (MULT_CYC < 1 || MULT_CYC > 15) begin : g_bad_mult_cyc
        $error("hazard_stall_ctrl: MULT_CYC must be in 1..15");
    end
    if (DIV_CYC < 1 || DIV_CYC > 15) begin : g_bad_div_cyc
        $error("hazard_stall_ctrl: DIV_CYC must be in 1..15");
    end

    localparam logic [3:0] L_MULT_CNT = 4'(MULT_CYC);
    localparam logic [3:0] L_DIV_CNT  = 4'(DIV_CYC);
    localparam logic [1:0] L_TUSE_NONE = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    md_state_t  r_state;
    logic [3:0] r_cnt;

    logic w_rs_e_hit;
    logic w_rs_m_hit;
    logic w_rt_e_hit;
    logic w_rt_m_hit;
    logic w_stall_rs;
    logic w_stall_rt;
    logic w_stall_md;
    logic w_stall;
    logic [3:0] w_start_cnt;

    // A source that is not read (Tuse==3) or names $0 can never depend on an older result.
    always_comb begin
        w_rs_e_hit = (D_rs == E_wa) && (D_tuse_rs < E_tnew);
        w_rs_m_hit = (D_rs == M_wa) && (D_tuse_rs < M_tnew);
        w_rt_e_hit = (D_rt == E_wa) && (D_tuse_rt < E_tnew);
        w_rt_m_hit = (D_rt == M_wa) && (D_tuse_rt < M_tnew);
        w_stall_rs = (D_rs != 5'd0) && (D_tuse_rs != L_TUSE_NONE) && (w_rs_e_hit || w_rs_m_hit);
        w_stall_rt = (D_rt != 5'd0) && (D_tuse_rt != L_TUSE_NONE) && (w_rt_e_hit || w_rt_m_hit);
        w_stall_md = D_is_md && (md_busy || E_md_start);
        w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
    end

    assign pc_we       = ~w_stall;
    assign d_we        = ~w_stall;
    assign e_flush     = w_stall;
    assign md_busy     = (r_state == S_BUSY);
    assign w_start_cnt = E_md_is_div ? L_DIV_CNT : L_MULT_CNT;

    // A start seen while already busy reloads the count with the new operation's latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (E_md_start) begin
                        r_state <= S_BUSY;
                        r_cnt   <= w_start_cnt;
                    end
                end
                S_BUSY: begin
                    if (E_md_start) begin
                        r_cnt <= w_start_cnt;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
